// File: rtl/friscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : friscv_pkg
// Description : Shared types and constants for the FRiscV core: XLEN, the
//               trap vector, PC source select encoding, fetch FSM states and
//               performance counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package friscv_pkg;

    localparam int XLEN       = 32;
    localparam int PERF_CNT_W = 32;

    // Address the fetch stage jumps to when a trap is taken
    localparam logic [XLEN-1:0] EXCEPTION_ADDRESS = 32'h0000_0100;

    typedef enum logic [1:0] {
        PC_SRC_IMM = 2'b00,
        PC_SRC_INC = 2'b01,
        PC_SRC_EXC = 2'b10,
        PC_SRC_RSV = 2'b11
    } pc_src_t;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        RUN        = 2'b01,
        TRAP_DRAIN = 2'b10,
        TRAP_JUMP  = 2'b11
    } fetch_state_t;

endpackage : friscv_pkg
`default_nettype wire

// File: rtl/fetch_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
//               Cleared by the asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_in,
    output logic [WIDTH-1:0] cnt_out
);

    logic [WIDTH-1:0] r_cnt;

    // Count enabled events, holding once every bit is set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (inc_in && (r_cnt != {WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign cnt_out = r_cnt;

endmodule : sat_counter
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Fetch-stage sequencer. Arbitrates exception > branch >
//               load-use stall > imem wait, drives PC select/enable, fetch
//               request and pipeline flush/hold, and runs the trap-entry
//               drain/jump sequence.
//               Optional macro FETCH_CTRL_PERF_CNT_EN adds saturating
//               stall/flush performance counters (tied to 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import friscv_pkg::*;
#(
    parameter int TRAP_DRAIN_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  imem_ack_in,
    input  logic                  branch_taken_in,
    input  logic                  stall_in,
    input  logic                  exception_in,
    input  logic [XLEN-1:0]       exc_pc_in,
    output logic [1:0]            pc_src_out,
    output logic                  pc_en_out,
    output logic                  imem_req_out,
    output logic                  if_id_hold_out,
    output logic                  if_id_flush_out,
    output logic                  id_ex_flush_out,
    output logic                  ex_mem_flush_out,
    output logic [XLEN-1:0]       epc_out,
    output logic [PERF_CNT_W-1:0] stall_cnt_out,
    output logic [PERF_CNT_W-1:0] flush_cnt_out
);

    // Drain counter preload: counts down to 0, giving TRAP_DRAIN_CYCLES cycles
    localparam logic [3:0] C_DRAIN_INIT = 4'(TRAP_DRAIN_CYCLES - 1);

    fetch_state_t    r_state;
    fetch_state_t    w_next_state;
    logic [3:0]      r_drain_cnt;
    logic [3:0]      w_drain_cnt_next;
    logic [XLEN-1:0] r_epc;
    logic            w_epc_load;
    pc_src_t         w_pc_src;

    // State, drain counter and captured EPC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_drain_cnt <= 4'd0;
            r_epc       <= '0;
        end else begin
            r_state     <= w_next_state;
            r_drain_cnt <= w_drain_cnt_next;
            if (w_epc_load) begin
                r_epc <= exc_pc_in;
            end
        end
    end

    // Next-state and output decode; RUN applies the priority chain
    always_comb begin
        w_next_state     = r_state;
        w_drain_cnt_next = r_drain_cnt;
        w_epc_load       = 1'b0;
        w_pc_src         = PC_SRC_INC;
        pc_en_out        = 1'b0;
        imem_req_out     = 1'b0;
        if_id_hold_out   = 1'b0;
        if_id_flush_out  = 1'b0;
        id_ex_flush_out  = 1'b0;
        ex_mem_flush_out = 1'b0;

        case (r_state)
            IDLE: begin
                w_next_state = RUN;
            end
            RUN: begin
                imem_req_out = 1'b1;
                if (exception_in) begin
                    w_epc_load       = 1'b1;
                    if_id_flush_out  = 1'b1;
                    id_ex_flush_out  = 1'b1;
                    ex_mem_flush_out = 1'b1;
                    w_drain_cnt_next = C_DRAIN_INIT;
                    w_next_state     = TRAP_DRAIN;
                end else if (branch_taken_in) begin
                    // Redirect regardless of ack; the un-acked fetch is dropped
                    w_pc_src        = PC_SRC_IMM;
                    pc_en_out       = 1'b1;
                    if_id_flush_out = 1'b1;
                    id_ex_flush_out = 1'b1;
                end else if (stall_in) begin
                    if_id_hold_out  = 1'b1;
                    id_ex_flush_out = 1'b1;
                end else if (!imem_ack_in) begin
                    if_id_flush_out = 1'b1;
                end else begin
                    pc_en_out = 1'b1;
                end
            end
            TRAP_DRAIN: begin
                if_id_flush_out  = 1'b1;
                id_ex_flush_out  = 1'b1;
                ex_mem_flush_out = 1'b1;
                if (r_drain_cnt != 4'd0) begin
                    w_drain_cnt_next = r_drain_cnt - 4'd1;
                end else begin
                    w_next_state = TRAP_JUMP;
                end
            end
            TRAP_JUMP: begin
                w_pc_src        = PC_SRC_EXC;
                pc_en_out       = 1'b1;
                if_id_flush_out = 1'b1;
                w_next_state    = RUN;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign pc_src_out = w_pc_src;
    assign epc_out    = r_epc;

`ifdef FETCH_CTRL_PERF_CNT_EN
    logic w_stall_inc;
    logic w_flush_inc;

    // Stall: RUN cycles that do not advance the PC.
    // Flush: taken branches plus trap entries (exception has priority).
    assign w_stall_inc = (r_state == RUN) && !pc_en_out;
    assign w_flush_inc = (r_state == RUN) && (exception_in || branch_taken_in);

    sat_counter #(.WIDTH(PERF_CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_in  (w_stall_inc),
        .cnt_out (stall_cnt_out)
    );

    sat_counter #(.WIDTH(PERF_CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_in  (w_flush_inc),
        .cnt_out (flush_cnt_out)
    );
`else
    assign stall_cnt_out = '0;
    assign flush_cnt_out = '0;
`endif

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl. Directed scenarios plus
//               randomized traffic compared cycle by cycle against a
//               behavioural model (trap tracked as a remaining-cycle count).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;
    import friscv_pkg::*;

    localparam int C_DRAIN = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  imem_ack_in = 1'b0;
    logic                  branch_taken_in = 1'b0;
    logic                  stall_in = 1'b0;
    logic                  exception_in = 1'b0;
    logic [XLEN-1:0]       exc_pc_in = '0;
    logic [1:0]            pc_src_out;
    logic                  pc_en_out;
    logic                  imem_req_out;
    logic                  if_id_hold_out;
    logic                  if_id_flush_out;
    logic                  id_ex_flush_out;
    logic                  ex_mem_flush_out;
    logic [XLEN-1:0]       epc_out;
    logic [PERF_CNT_W-1:0] stall_cnt_out;
    logic [PERF_CNT_W-1:0] flush_cnt_out;

    fetch_ctrl #(.TRAP_DRAIN_CYCLES(C_DRAIN)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_ack_in      (imem_ack_in),
        .branch_taken_in  (branch_taken_in),
        .stall_in         (stall_in),
        .exception_in     (exception_in),
        .exc_pc_in        (exc_pc_in),
        .pc_src_out       (pc_src_out),
        .pc_en_out        (pc_en_out),
        .imem_req_out     (imem_req_out),
        .if_id_hold_out   (if_id_hold_out),
        .if_id_flush_out  (if_id_flush_out),
        .id_ex_flush_out  (id_ex_flush_out),
        .ex_mem_flush_out (ex_mem_flush_out),
        .epc_out          (epc_out),
        .stall_cnt_out    (stall_cnt_out),
        .flush_cnt_out    (flush_cnt_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: started flag, cycles left in the trap sequence
    // (C_DRAIN drain cycles then one jump cycle), EPC and event tallies.
    bit          m_started;
    int          m_trap_left;
    logic [31:0] m_epc;
    int unsigned m_stalls;
    int unsigned m_flushes;

    // Expected outputs for the current cycle
    logic [1:0] e_src;
    logic       e_pen, e_req, e_hold, e_iff, e_ief, e_emf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started   = 1'b0;
        m_trap_left = 0;
        m_epc       = '0;
        m_stalls    = 0;
        m_flushes   = 0;
    endtask

    task automatic model_outputs();
        e_src = PC_SRC_INC; e_pen = 0; e_req = 0; e_hold = 0;
        e_iff = 0; e_ief = 0; e_emf = 0;
        if (!rst_n || !m_started) begin
            // everything idle
        end else if (m_trap_left > 1) begin
            e_iff = 1; e_ief = 1; e_emf = 1;
        end else if (m_trap_left == 1) begin
            e_src = PC_SRC_EXC; e_pen = 1; e_iff = 1;
        end else begin
            e_req = 1;
            if (exception_in) begin
                e_iff = 1; e_ief = 1; e_emf = 1;
            end else if (branch_taken_in) begin
                e_src = PC_SRC_IMM; e_pen = 1; e_iff = 1; e_ief = 1;
            end else if (stall_in) begin
                e_hold = 1; e_ief = 1;
            end else if (!imem_ack_in) begin
                e_iff = 1;
            end else begin
                e_pen = 1;
            end
        end
    endtask

    task automatic check_all();
        model_outputs();
        check("pc_src", 32'(pc_src_out), 32'(e_src));
        check("pc_en", 32'(pc_en_out), 32'(e_pen));
        check("imem_req", 32'(imem_req_out), 32'(e_req));
        check("if_id_hold", 32'(if_id_hold_out), 32'(e_hold));
        check("if_id_flush", 32'(if_id_flush_out), 32'(e_iff));
        check("id_ex_flush", 32'(id_ex_flush_out), 32'(e_ief));
        check("ex_mem_flush", 32'(ex_mem_flush_out), 32'(e_emf));
        check("epc", epc_out, m_epc);
`ifdef FETCH_CTRL_PERF_CNT_EN
        check("stall_cnt", stall_cnt_out, m_stalls);
        check("flush_cnt", flush_cnt_out, m_flushes);
`else
        check("stall_cnt", stall_cnt_out, 32'd0);
        check("flush_cnt", flush_cnt_out, 32'd0);
`endif
    endtask

    // Advance the model by one clock edge using the inputs held this cycle
    task automatic model_edge();
        bit in_run;
        in_run = m_started && (m_trap_left == 0);
        if (in_run && !e_pen && m_stalls != 32'hFFFF_FFFF) m_stalls++;
        if (!m_started) begin
            m_started = 1'b1;
        end else if (m_trap_left > 0) begin
            m_trap_left--;
        end else if (exception_in) begin
            m_epc       = exc_pc_in;
            m_trap_left = C_DRAIN + 1;
            m_flushes++;
        end else if (branch_taken_in) begin
            m_flushes++;
        end
    endtask

    // One cycle: drive on the falling edge, check, then follow the rising edge
    task automatic step(input logic ack, input logic br, input logic st,
                        input logic ex, input logic [31:0] pc);
        @(negedge clk);
        imem_ack_in     = ack;
        branch_taken_in = br;
        stall_in        = st;
        exception_in    = ex;
        exc_pc_in       = pc;
        #1;
        check_all();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    // Asynchronous reset applied mid-cycle; outputs must drop at once
    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Cycle 0 idle, then normal fetch
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);

        // Single-cycle branch, with and without ack
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Stall with no ack for 3 cycles
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);

        // Exception with simultaneous branch, then ignored events in drain
        step(1, 1, 0, 1, 32'h0000_0040);
        step(1, 1, 0, 1, 32'h0000_0080);
        step(1, 1, 1, 1, 32'h0000_00C0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("epc_after_trap", epc_out, 32'h0000_0040);

        // Reset during drain
        step(1, 0, 0, 1, 32'h0000_1234);
        step(1, 0, 0, 0, 0);
        pulse_reset();
        check("epc_cleared", epc_out, 32'h0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(3, 0) != 0),
                 ($urandom_range(5, 0) == 0),
                 ($urandom_range(3, 0) == 0),
                 ($urandom_range(15, 0) == 0),
                 $urandom);
            if ($urandom_range(499, 0) == 0) pulse_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_ctrl
`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage sequencer for the pipelined FRiscV core. It drives the program-counter source select and update enable, the instruction-memory request, and the pipeline-register flush/hold controls. It resolves priority between exceptions, taken branches, load-use stalls and instruction-memory wait states, and runs a multi-cycle trap-entry sequence. It sits between the hazard/branch logic in ID/EX and the PC register plus IF/ID, ID/EX and EX/MEM pipeline registers.

## Interface
- TRAP_DRAIN_CYCLES, 2: number of full-flush drain cycles before the jump to the exception address; legal range 1..15.
- clk  in  1  core clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_ack_in  in  1  instruction memory accepts the current fetch address this cycle (combinational ready).
- branch_taken_in  in  1  taken branch/jump resolved in EX; target is PC + immediate.
- stall_in  in  1  load-use hazard: hold the PC and IF/ID, and insert a bubble into ID/EX.
- exception_in  in  1  synchronous exception raised in EX.
- exc_pc_in  in  XLEN  PC of the excepting instruction.
- pc_src_out  out  2  pc_src_t select for the PC source mux.
- pc_en_out  out  1  PC register update enable.
- imem_req_out  out  1  fetch request.
- if_id_hold_out  out  1  IF/ID register hold.
- if_id_flush_out, id_ex_flush_out, ex_mem_flush_out  out  1 each  load a bubble into that pipeline register.
- epc_out  out  XLEN  captured PC of the excepting instruction.
- stall_cnt_out, flush_cnt_out  out  PERF_CNT_W each  performance counters.

## Operation
- States: IDLE, RUN, TRAP_DRAIN, TRAP_JUMP. Registered items: the state, the 4-bit drain counter, epc, and the performance counters. All other outputs are combinational from the state and inputs.
- Default outputs in every state: pc_src_out=PC_SRC_INC, with every enable, flush and hold output at 0.
- IDLE: imem_req_out=0. Always moves to RUN on the next edge. This is the only state entered from reset.
- RUN: imem_req_out=1. The first matching rule below applies:
  - exception_in: epc <= exc_pc_in; assert all three flushes; pc_en_out=0; drain counter <= TRAP_DRAIN_CYCLES-1; next state TRAP_DRAIN.
  - branch_taken_in: pc_src_out=PC_SRC_IMM; pc_en_out=1; assert if_id_flush_out and id_ex_flush_out; stay in RUN. The branch is taken even if imem_ack_in=0, and the un-acked fetch is discarded.
  - stall_in: pc_en_out=0; if_id_hold_out=1; id_ex_flush_out=1.
  - !imem_ack_in: pc_en_out=0; if_id_flush_out=1 (fetch bubble).
  - Otherwise: pc_src_out=PC_SRC_INC; pc_en_out=1.
- TRAP_DRAIN: imem_req_out=0, pc_en_out=0, all flushes=1. exception_in and branch_taken_in are ignored. While the counter is nonzero, decrement it. When the counter reaches 0, the next state is TRAP_JUMP.
- TRAP_JUMP: pc_src_out=PC_SRC_EXC; pc_en_out=1; if_id_flush_out=1; imem_req_out=0. Next state RUN.
- epc changes only on trap entry and holds its value otherwise.

## Timing
- Reset (asynchronous): state=IDLE, epc_out=0, counters=0. With rst_n low, outputs are pc_src_out=PC_SRC_INC and every other output 0.
- First fetch request, for PC 0, is issued in the second cycle after rst_n deasserts.
- Branch: redirect is zero-latency. The PC loads the target on the same edge that branch_taken_in is sampled, and IF/ID and ID/EX are flushed that edge.
- Trap: from exception_in to the PC loading EXCEPTION_ADDRESS takes 1 + TRAP_DRAIN_CYCLES + 1 cycles (4 with the default). The fetch at EXCEPTION_ADDRESS happens in the following RUN cycle.
- Exception and branch together: exception wins and the branch is dropped.
- Stall and !ack together: stall wins; no fetch bubble is inserted and IF/ID is held.
- Asynchronous reset mid-trap aborts the sequence immediately: state returns to IDLE and epc is cleared.

## Configuration
- FETCH_CTRL_PERF_CNT_EN defined:
  - stall_cnt_out counts RUN cycles with pc_en_out=0.
  - flush_cnt_out counts taken branches plus trap entries.
  - Both counters are PERF_CNT_W wide, saturate at all-ones, and clear on reset.
- Not defined: the ports still exist, both counters are tied to 0, and no counter flops are present.

## Structure
- friscv_pkg holds:
  - pc_src_t: PC_SRC_IMM=2'b00, PC_SRC_INC=2'b01, PC_SRC_EXC=2'b10, PC_SRC_RSV=2'b11.
  - fetch_state_t and PERF_CNT_W=32.
  - EXCEPTION_ADDRESS and XLEN, which already exist there.
- One sub-module, sat_counter (parameter WIDTH; inputs clk, rst_n, inc_in; output cnt_out), instantiated twice under the macro.

## Test plan
- Reset released at cycle 0: cycle 0 has imem_req_out=0; cycle 1 has imem_req_out=1 and pc_en_out=1 with ack=1; epc_out=0.
- branch_taken_in=1 for one cycle in RUN: pc_src_out=2'b00, pc_en_out=1, if_id_flush_out and id_ex_flush_out high for exactly that cycle.
- stall_in=1 with imem_ack_in=0 for 3 cycles: pc_en_out=0, if_id_hold_out=1, id_ex_flush_out=1, if_id_flush_out=0. With the macro defined, stall_cnt_out=3.
- exception_in=1 with exc_pc_in=32'h0000_0040 and a simultaneous branch, TRAP_DRAIN_CYCLES=2:
  - epc_out=32'h40.
  - Two drain cycles with all flushes high and imem_req_out=0.
  - A TRAP_JUMP cycle with pc_src_out=2'b10 and pc_en_out=1.
  - RUN on the next cycle; flush_cnt_out=1.
- rst_n pulsed low during TRAP_DRAIN: outputs return to reset values immediately, and the sequence restarts from IDLE.
- Macro undefined: 10 stall cycles leave stall_cnt_out=0 and flush_cnt_out=0.
